// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] BOOT_SYNC_DEFAULT = 8'hA5;
    localparam int         BOOT_LEN_W        = 16;
    localparam int         BOOT_WORD_W       = 32;

endpackage

// File: rtl/boot_word_packer.sv
// Packs four consecutive bytes into one little-endian 32-bit word.
// word_vld_o pulses for one cycle, the cycle after the fourth byte.
module boot_word_packer
    import boot_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_i,
    input  logic                   byte_vld_i,
    input  logic                   clear_i,
    output logic [BOOT_WORD_W-1:0] word_o,
    output logic                   word_vld_o
);

    logic [1:0]             idx_q, idx_d;
    logic [BOOT_WORD_W-1:0] word_q, word_d;
    logic                   vld_q, vld_d;

    // Next-state: place the byte at its LE lane, flag completion on lane 3.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        vld_d  = 1'b0;
        if (clear_i) begin
            idx_d = 2'd0;
        end else if (byte_vld_i) begin
            word_d[8*idx_q +: 8] = byte_i;
            idx_d                = idx_q + 2'd1;
            vld_d                = (idx_q == 2'd3);
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign word_o     = word_q;
    assign word_vld_o = vld_q;

endmodule

// File: rtl/boot_loader.sv
// Boot packet parser: pops bytes from the boot FIFO, writes LE words to
// imem from address 0 and releases the CPU once the packet is accepted.
// Optional trailing checksum byte enabled by `BOOT_LOADER_CHECKSUM_EN.
module boot_loader
    import boot_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter int         MAX_WORDS  = 1024,
    parameter logic [7:0] SYNC_BYTE  = BOOT_SYNC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [7:0]             fifo_rd_data,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [BOOT_WORD_W-1:0] imem_wdata,
    output logic                   cpu_rst,
    output logic                   boot_done,
    output logic                   boot_err
);

    localparam logic [BOOT_LEN_W:0] MAX_W = (BOOT_LEN_W+1)'(MAX_WORDS);

    state_t                 state_q, state_d;
    logic                   byte_vld_q;
    logic [BOOT_LEN_W-1:0]  len_q, len_d;
    logic [BOOT_LEN_W-1:0]  cnt_q, cnt_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    logic                   pop_ok;
    logic                   pk_clear;
    logic                   pk_vld;
    logic [BOOT_WORD_W-1:0] pk_word;
    logic [BOOT_LEN_W-1:0]  len_full;
    logic                   len_bad;
    logic                   last_word;

    assign len_full  = {fifo_rd_data, len_q[7:0]};
    assign len_bad   = (len_full == '0) || ({1'b0, len_full} > MAX_W);
    assign last_word = (cnt_q == len_q - 16'd1);

    // Next-state / control: FSM only advances on a valid popped byte.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        pk_clear = 1'b0;
        pop_ok   = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            IDLE: begin
                pop_ok = 1'b1;
                if (byte_vld_q && fifo_rd_data == SYNC_BYTE) begin
                    state_d = LEN_LO;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            LEN_LO: begin
                pop_ok = 1'b1;
                if (byte_vld_q) begin
                    len_d[7:0] = fifo_rd_data;
                    state_d    = LEN_HI;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + fifo_rd_data;
`endif
                end
            end
            LEN_HI: begin
                pop_ok = 1'b1;
                if (byte_vld_q) begin
                    len_d[15:8] = fifo_rd_data;
                    cnt_d       = '0;
                    pk_clear    = 1'b1;
                    state_d     = len_bad ? ERR : DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + fifo_rd_data;
`endif
                end
            end
            DATA: begin
                // While the final word is being written, hold off: the next
                // FIFO byte does not belong to the payload.
                pop_ok = !(pk_vld && last_word);
                if (pk_vld) begin
                    cnt_d = cnt_q + 16'd1;
                    if (last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (byte_vld_q) sum_d = sum_q + fifo_rd_data;
`endif
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK: begin
                pop_ok = 1'b1;
                if (byte_vld_q) state_d = (fifo_rd_data == sum_q) ? DONE : ERR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // State, counters and pop-in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_vld_q <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_vld_q <= fifo_rd_en;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_i     (fifo_rd_data),
        .byte_vld_i (byte_vld_q && state_q == DATA),
        .clear_i    (pk_clear),
        .word_o     (pk_word),
        .word_vld_o (pk_vld)
    );

    assign fifo_rd_en = pop_ok && !fifo_empty && !byte_vld_q;
    assign imem_we    = pk_vld;
    assign imem_addr  = cnt_q[ADDR_WIDTH-1:0];
    assign imem_wdata = pk_word;
    assign boot_done  = (state_q == DONE);
    assign boot_err   = (state_q == ERR);
    assign cpu_rst    = (state_q != DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: FIFO model feeding byte queues, imem capture,
// and a packet-level reference computing the expected outcome.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        boot_done;
    logic        boot_err;

    always #5 clk = ~clk;

    boot_loader dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .boot_done    (boot_done),
        .boot_err     (boot_err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  fq[$];
    int          pops, stall_at, stall_len, stall_cnt;
    bit          rnd_stall;
    int          empty_viol, both_viol, wr_cnt;
    logic [31:0] mem [0:1023];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // FIFO model: decide empty at negedge, then pop if the DUT requests.
    initial begin
        fifo_empty   = 1'b1;
        fifo_rd_data = 8'h00;
        pops = 0; stall_at = 0; stall_len = 0; stall_cnt = 0; rnd_stall = 0;
        empty_viol = 0;
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) stall_cnt--;
            fifo_empty = (fq.size() == 0) || (stall_cnt > 0) ||
                         (rnd_stall && $urandom_range(0, 2) == 0);
            #1;
            if (fifo_rd_en && fifo_empty) empty_viol++;
            if (fifo_rd_en && !fifo_empty) begin
                fifo_rd_data = fq.pop_front();
                pops++;
                if (pops == stall_at) stall_cnt = stall_len + 1;
            end
        end
    end

    // imem capture and output invariants.
    initial begin
        wr_cnt = 0; both_viol = 0;
        forever begin
            @(negedge clk);
            #2;
            if (imem_we) begin
                mem[imem_addr] = imem_wdata;
                wr_cnt++;
            end
            if (boot_done && boot_err) both_viol++;
        end
    end

    // Packet-level reference: what the loader should do with byte stream b.
    task automatic model(input logic [7:0] b[$], output bit e_done, output bit e_err,
                         output int e_cons, output logic [31:0] w[$]);
        int i, len, sum;
        logic [31:0] wd;
        w = {};
        i = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        i++;
        len = int'(b[i]) + 256 * int'(b[i+1]);
        sum = int'(b[i]) + int'(b[i+1]);
        i += 2;
        e_done = 0; e_err = 0;
        if (len == 0 || len > 1024) begin
            e_err = 1;
        end else begin
            for (int k = 0; k < len; k++) begin
                wd = {b[i+3], b[i+2], b[i+1], b[i]};
                sum += int'(b[i]) + int'(b[i+1]) + int'(b[i+2]) + int'(b[i+3]);
                w.push_back(wd);
                i += 4;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            e_done = (int'(b[i]) == sum % 256);
            e_err  = !e_done;
            i++;
`else
            e_done = 1;
`endif
        end
        e_cons = i;
    endtask

    task automatic do_reset(input string nm);
        fq.delete();
        rnd_stall = 0; stall_cnt = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk({nm, ":rst_cpu"},  32'(cpu_rst),   32'd1);
        chk({nm, ":rst_done"}, 32'(boot_done), 32'd0);
        chk({nm, ":rst_err"},  32'(boot_err),  32'd0);
        chk({nm, ":rst_we"},   32'(imem_we),   32'd0);
        rst = 1'b0;
    endtask

    task automatic run_case(input string nm, input logic [7:0] b[$], input int s_at,
                            input int s_len, input bit rs, input bit skip_rst);
        bit e_done, e_err;
        int e_cons, n;
        logic [31:0] w[$];
        model(b, e_done, e_err, e_cons, w);
        if (!skip_rst) do_reset(nm);
        for (int k = 0; k < 64; k++) mem[k] = 32'hDEADBEEF;
        pops = 0; empty_viol = 0; both_viol = 0; wr_cnt = 0;
        stall_at = s_at; stall_len = s_len; rnd_stall = rs;
        fq = b;
        n = 0;
        while (!(boot_done || boot_err) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ":finished"}, 32'(n < 3000), 32'd1);
        repeat (12) @(negedge clk);
        #3;
        chk({nm, ":done"},    32'(boot_done), 32'(e_done));
        chk({nm, ":err"},     32'(boot_err),  32'(e_err));
        chk({nm, ":cpu_rst"}, 32'(cpu_rst),   32'(!e_done));
        chk({nm, ":writes"},  32'(wr_cnt),    32'(w.size()));
        for (int k = 0; k < w.size() && k < 64; k++)
            chk($sformatf("%s:imem[%0d]", nm, k), mem[k], w[k]);
        chk({nm, ":consumed"},   32'(pops),       32'(e_cons));
        chk({nm, ":rd_empty"},   32'(empty_viol), 32'd0);
        chk({nm, ":done_err"},   32'(both_viol),  32'd0);
    endtask

    initial begin
        logic [7:0] pkt1[$];
        logic [7:0] p[$];
        int len, sum, n;
        logic [7:0] bv;

        pkt1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};

        run_case("t1", pkt1, 0, 0, 0, 0);

        p = {8'h00, 8'hFF, 8'h5A};
        p = {p, pkt1};
        run_case("t2", p, 0, 0, 0, 0);

        p = pkt1;
        p[11] = 8'hB9;
        run_case("t3", p, 0, 0, 0, 0);

        p = '{8'hA5, 8'h00, 8'h00, 8'h11, 8'h22};
        run_case("t4a", p, 0, 0, 0, 0);
        p = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22};
        run_case("t4b", p, 0, 0, 0, 0);

        // Stall after 6 pops: between bytes 2 and 3 of word 0.
        run_case("t5", pkt1, 6, 20, 0, 0);

        // Reset after word 0 lands, then a fresh packet.
        do_reset("t6");
        wr_cnt = 0; pops = 0;
        fq = pkt1;
        n = 0;
        while (wr_cnt < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t6:w0_seen", 32'(n < 500), 32'd1);
        chk("t6:w0", mem[0], 32'h00000013);
        rst = 1'b1;
        fq.delete();
        @(negedge clk);
        #3;
        chk("t6:mid_cpu",  32'(cpu_rst),    32'd1);
        chk("t6:mid_done", 32'(boot_done),  32'd0);
        chk("t6:mid_err",  32'(boot_err),   32'd0);
        chk("t6:mid_we",   32'(imem_we),    32'd0);
        chk("t6:mid_rd",   32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_case("t6b", pkt1, 0, 0, 0, 1);

        // Randomized packets with garbage prefixes, random stalls, bad
        // lengths and corrupted checksums.
        for (int i = 0; i < 16; i++) begin
            p = {};
            repeat ($urandom_range(0, 3)) begin
                bv = 8'($urandom_range(0, 255));
                if (bv == 8'hA5) bv = 8'h00;
                p.push_back(bv);
            end
            p.push_back(8'hA5);
            if (i % 6 == 4) len = (i % 12 == 4) ? 0 : 1025 + $urandom_range(0, 100);
            else            len = $urandom_range(1, 6);
            p.push_back(8'(len & 255));
            p.push_back(8'(len >> 8));
            sum = (len & 255) + (len >> 8);
            if (len >= 1 && len <= 1024) begin
                repeat (4 * len) begin
                    bv = 8'($urandom_range(0, 255));
                    sum += int'(bv);
                    p.push_back(bv);
                end
                p.push_back(8'((sum + ((i % 5 == 2) ? 1 : 0)) & 255));
            end
            p.push_back(8'($urandom_range(0, 255)));
            run_case($sformatf("rnd%0d", i), p, 0, 0, bit'(i % 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
